// File: rtl/alu_32.sv
// Registered 32-bit ALU: eight logic/arithmetic ops with carry, negative, zero and overflow flags.
// ADD and SUB share one ripple adder built from full-adder cells; every output is registered.
module alu_32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] result,
  output logic        c,
  output logic        n,
  output logic        z,
  output logic        v
);

  typedef enum logic [2:0] {
    OP_NOTA = 3'b000,
    OP_NOTB = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ADD  = 3'b110,
    OP_SUB  = 3'b111
  } op_e;

  logic        w_isSub;
  logic        w_isArith;
  logic [31:0] w_addB;
  logic [31:0] w_sum;
  logic [32:0] w_carry;
  logic [31:0] w_res;
  logic        w_c;
  logic        w_v;

  logic [31:0] r_result;
  logic        r_c;
  logic        r_n;
  logic        r_z;
  logic        r_v;

  assign w_isSub    = (op == OP_SUB);
  assign w_isArith  = (op == OP_ADD) || (op == OP_SUB);
  // SUB reuses the adder as a + ~b + 1
  assign w_addB     = w_isSub ? ~b : b;
  assign w_carry[0] = w_isSub;

  for (genvar i = 0; i < 32; i++) begin : g_fullAdder
    assign w_sum[i]       = a[i] ^ w_addB[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a[i] & w_addB[i]) | (w_carry[i] & (a[i] ^ w_addB[i]));
  end

  always_comb begin
    w_res = 32'h0;
    case (op_e'(op))
      OP_NOTA: w_res = ~a;
      OP_NOTB: w_res = ~b;
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_XNOR: w_res = ~(a ^ b);
      OP_ADD:  w_res = w_sum;
      OP_SUB:  w_res = w_sum;
      default: w_res = 32'h0;
    endcase
  end

  // Overflow: the effective operands agree in sign but the sum does not
  assign w_c = w_isArith & w_carry[32];
  assign w_v = w_isArith & (a[31] == w_addB[31]) & (w_sum[31] != a[31]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= 32'h0;
      r_c      <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      r_result <= w_res;
      r_c      <= w_c;
      r_n      <= w_res[31];
      r_z      <= (w_res == 32'h0);
      r_v      <= w_v;
    end
  end

  assign result = r_result;
  assign c      = r_c;
  assign n      = r_n;
  assign z      = r_z;
  assign v      = r_v;

endmodule

// File: tb/tb_alu_32.sv
// Scoreboard bench for alu_32: stimulus pushes expected results from a plain-arithmetic model,
// a monitor pops one entry after each rising edge and compares all outputs.
module tb_alu_32;

  typedef struct {
    logic [31:0] result;
    logic        c;
    logic        n;
    logic        z;
    logic        v;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic [2:0]  op = 3'b000;
  logic [31:0] result;
  logic        c;
  logic        n;
  logic        z;
  logic        v;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  alu_32 dut (
    .clk    (clk),
    .reset_n(reset_n),
    .a      (a),
    .b      (b),
    .op     (op),
    .result (result),
    .c      (c),
    .n      (n),
    .z      (z),
    .v      (v)
  );

  always #5 clk = ~clk;

  // Reference model: results from ordinary wide integer arithmetic
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic [2:0] mop, input string nm);
    exp_t e;
    longint unsigned uSum;
    longint sRes;
    e.name = nm;
    e.c = 1'b0;
    e.v = 1'b0;
    case (mop)
      3'd0: e.result = ~ma;
      3'd1: e.result = ~mb;
      3'd2: e.result = ma & mb;
      3'd3: e.result = ma | mb;
      3'd4: e.result = ma ^ mb;
      3'd5: e.result = ~(ma ^ mb);
      3'd6: begin
        uSum = longint'({32'h0, ma}) + longint'({32'h0, mb});
        e.result = ma + mb;
        e.c = (uSum > 64'h0000_0000_FFFF_FFFF);
        sRes = longint'($signed(ma)) + longint'($signed(mb));
        e.v = (sRes > 64'sd2147483647) || (sRes < -64'sd2147483648);
      end
      default: begin
        e.result = ma - mb;
        e.c = (ma >= mb);
        sRes = longint'($signed(ma)) - longint'($signed(mb));
        e.v = (sRes > 64'sd2147483647) || (sRes < -64'sd2147483648);
      end
    endcase
    e.n = e.result[31];
    e.z = (e.result == 32'h0);
    return e;
  endfunction

  task automatic checkOutput(input exp_t e);
    checks++;
    if ({result, c, n, z, v} !== {e.result, e.c, e.n, e.z, e.v}) begin
      errors++;
      $display("[TB] FAIL %s: got result=%h c=%b n=%b z=%b v=%b, expected result=%h c=%b n=%b z=%b v=%b",
               e.name, result, c, n, z, v, e.result, e.c, e.n, e.z, e.v);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] sa, input logic [31:0] sb,
                               input logic [2:0] sop, input string nm);
    @(negedge clk);
    a  = sa;
    b  = sb;
    op = sop;
    expQ.push_back(model(sa, sb, sop, nm));
  endtask

  function automatic exp_t resetExp(input string nm);
    exp_t e;
    e.result = 32'h0;
    e.c = 1'b0;
    e.n = 1'b0;
    e.z = 1'b0;
    e.v = 1'b0;
    e.name = nm;
    return e;
  endfunction

  // Monitor: the entry pushed before an edge is the response visible just after it
  initial begin
    forever begin
      @(posedge clk);
      if (reset_n && expQ.size() > 0) begin
        #1;
        checkOutput(expQ.pop_front());
      end
    end
  end

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1 reset_n = 1'b0;
    #1 checkOutput(resetExp("async_reset"));
    repeat (2) @(posedge clk);
    #1 checkOutput(resetExp("reset_held"));
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(32'h0, 32'h0, 3'b110, "add_zero_after_reset");
    applyStimulus(32'h0, 32'h0, 3'b000, "nota_0");
    applyStimulus(32'hFFFF_FFFC, 32'h0, 3'b000, "nota_fffffffc");
    applyStimulus(32'h0, 32'h3, 3'b001, "notb_3");
    applyStimulus(32'h5, 32'h9, 3'b010, "and_5_9");
    applyStimulus(32'h5, 32'hA, 3'b011, "or_5_a");
    applyStimulus(32'h3, 32'h5, 3'b100, "xor_3_5");
    applyStimulus(32'h3, 32'h5, 3'b101, "xnor_3_5");
    applyStimulus(32'hFFFF_FFFF, 32'hF, 3'b110, "add_carry");
    applyStimulus(32'h7FFF_FFFF, 32'h1, 3'b110, "add_overflow");
    applyStimulus(32'hFFFF_FFFF, 32'h1, 3'b110, "add_wrap_zero");
    applyStimulus(32'h7, 32'h7, 3'b110, "add_7_7");
    applyStimulus(32'hF, 32'h5, 3'b111, "sub_f_5");
    applyStimulus(32'h5, 32'h7, 3'b111, "sub_borrow");
    applyStimulus(32'hA, 32'hA, 3'b111, "sub_equal");
    applyStimulus(32'h8000_0000, 32'h1, 3'b111, "sub_neg_overflow");
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b111, "sub_pos_overflow");

    // Back-to-back sweep of every opcode, one per cycle
    for (int i = 0; i < 16; i++)
      applyStimulus($urandom(), $urandom(), 3'(i % 8), $sformatf("sweep_%0d", i));

    // Mid-stream reset: the pending ADD is never pushed because reset discards it
    @(negedge clk);
    a  = 32'h7FFF_FFFF;
    b  = 32'h1;
    op = 3'b110;
    #2 reset_n = 1'b0;
    #1 checkOutput(resetExp("midstream_reset"));
    a  = 32'h1;
    b  = 32'h2;
    op = 3'b110;
    expQ.push_back(model(32'h1, 32'h2, 3'b110, "after_midstream_reset"));
    #1 reset_n = 1'b1;

    for (int i = 0; i < 300; i++)
      applyStimulus(randOperand(), randOperand(), 3'($urandom_range(0, 7)),
                    $sformatf("random_%0d", i));

    repeat (2) @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d responses still pending, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_32.md
# alu_32

Registered 32-bit arithmetic/logic unit that executes one of eight operations on two 32-bit operands and produces a result with four status flags (carry, negative, zero, overflow). It is the execution block of the datapath: operands and opcode come from the register/decode stage, and result and flags go to writeback and the flag register. All inputs are captured and all outputs are registered on one clock.

## Interface
- No parameters. Width is fixed at 32 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- a  input  32  operand A.
- b  input  32  operand B.
- op  input  3  operation select.
- result  output  32  registered operation result.
- c  output  1  registered carry flag.
- n  output  1  registered negative flag.
- z  output  1  registered zero flag.
- v  output  1  registered signed-overflow flag.

## Operation
- Opcode map:
  - 000: NOT A (~a)
  - 001: NOT B (~b)
  - 010: a AND b
  - 011: a OR b
  - 100: a XOR b
  - 101: a XNOR b, i.e. ~(a^b)
  - 110: ADD, a + b
  - 111: SUB, a − b, computed as a + ~b + 1
- Arithmetic uses a single shared 32-bit adder built from full-adder cells. Ripple or carry-lookahead is acceptable.
  - Its B input is b for ADD and ~b for SUB.
  - Its carry-in is 0 for ADD and 1 for SUB.
- Result is the low 32 bits of the operation. The adder carry-out is never part of result.
- n = result[31] for every opcode.
- z = 1 iff result == 32'h0 for every opcode.
- c:
  - ADD: carry-out of bit 31.
  - SUB: carry-out of bit 31 of a + ~b + 1. This is 1 when a ≥ b unsigned, meaning no borrow.
  - Logic ops (000–101): 0.
- v:
  - ADD: (a[31] == b[31]) && (result[31] != a[31]).
  - SUB: (a[31] != b[31]) && (result[31] != a[31]).
  - Logic ops: 0.
- Unsigned wrap-around is silent. 32'hFFFFFFFF + 1 gives result 0, c=1, z=1, v=0.

## Timing
- The combinational ALU function is evaluated from the current a, b and op.
- result, c, n, z and v are registered on the rising edge of clk.
- Latency is 1 cycle: inputs present before edge k appear at the outputs after edge k.
- Throughput is one operation per cycle, with no handshake and no stall. A new op can be issued every cycle.
- Outputs hold their values until the next rising edge.
- Reset:
  - reset_n low immediately (asynchronously) forces result=32'h0 and c=n=z=v=0. z is defined as 0 in reset, not derived from the zero result.
  - Outputs stay in reset while reset_n is low.
  - The first capture is on the first rising edge with reset_n high.
- Reset asserted mid-stream discards the in-flight result. No partial-state recovery is required.
- X or Z inputs are not required to produce defined outputs. All-known inputs must produce all-known outputs.

## Test plan
- Reset: drive reset_n=0 at any time -> result=0, c=n=z=v=0 without waiting for a clk edge. Release it, apply a=0, b=0, op=110 -> after one edge result=0, z=1, c=n=v=0.
- Logic ops, each checked after one edge, with c=v=0 in every case:
  - op=000, a=0 -> result=FFFFFFFF, n=1, z=0.
  - op=000, a=FFFFFFFC -> result=00000003, n=0.
  - op=001, b=3 -> FFFFFFFC, n=1.
  - op=010, a=5, b=9 -> 00000001.
  - op=011, a=5, b=A -> 0000000F.
  - op=100, a=3, b=5 -> 00000006.
  - op=101, a=3, b=5 -> FFFFFFF9, n=1.
- ADD:
  - a=FFFFFFFF, b=F -> result=0000000E, c=1, v=0, n=0.
  - a=7FFFFFFF, b=1 -> 80000000, v=1, n=1, c=0.
  - a=FFFFFFFF, b=1 -> 0, c=1, z=1, v=0.
  - a=7, b=7 -> 0000000E, c=0, v=0.
- SUB:
  - a=F, b=5 -> 0000000A, c=1, n=0.
  - a=5, b=7 -> FFFFFFFE, c=0, n=1, v=0.
  - a=A, b=A -> 0, z=1, c=1, v=0.
  - a=80000000, b=1 -> 7FFFFFFF, v=1, c=1, n=0.
  - a=7FFFFFFF, b=FFFFFFFF -> 80000000, v=1, n=1, c=0.
- Pipelining: change a, b and op on every consecutive edge across all 8 opcodes -> each output set matches the inputs from exactly one edge earlier, with no bubbles.
- Mid-stream reset: pulse reset_n low between edges while ADD 7FFFFFFF+1 is pending -> outputs are 0 immediately. After release, the next captured op is unaffected by the pre-reset operands.
